// File: rtl/display_arbiter_if.sv
// display_arbiter_if: requester bus and display-side outputs of the display arbiter
interface display_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] data_in;
  logic [NUM_REQ-1:0]    grant;
  logic [2:0]            owner_id;
  logic [31:0]           numero_out;
  logic                  power_on;
  logic                  switch_pulse;
  modport master (
    output req, data_in,
    input  grant, owner_id, numero_out, power_on, switch_pulse
  );
  modport slave (
    input  req, data_in,
    output grant, owner_id, numero_out, power_on, switch_pulse
  );
endinterface

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin owner of the hex display with a minimum hold time
module display_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 100000000
) (
  input logic clk,
  input logic reset_n,
  display_arbiter_if.slave bus
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;
  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d, mreq, sh;
  logic [2:0]            owner_q, owner_d, ptr_q, ptr_d, win;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           numero_q, numero_d;
  logic [32*NUM_REQ-1:0] dsh;
  logic                  power_q, sw_q, any, own_req, take, drop;
  assign dsh = bus.data_in >> {owner_q, 5'b0};
  // Round-robin winner among non-owner requests, scanning upward from the pointer
  always_comb begin
    mreq    = bus.req & ~grant_q;
    any     = |mreq;
    own_req = |(bus.req & grant_q);
    win     = ptr_q;
    sh      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sh = mreq >> 3'((int'(ptr_q) + k) % NUM_REQ);
      if (sh[0]) win = 3'((int'(ptr_q) + k) % NUM_REQ);
    end
  end
  // Next state: once the hold count reaches 0, pending requests hand over with no idle gap
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
    take    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: take = any;
      HOLD: begin
        take = any & (!own_req | cnt_q == '0);
        drop = !own_req & !any;
        if (own_req & cnt_q == '0 & !any) state_d = OPEN;
      end
      OPEN: begin
        take = any;
        drop = !own_req & !any;
      end
      default: drop = 1'b1;
    endcase
    if (take) begin
      state_d = HOLD;
      grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
      owner_d = win;
      ptr_d   = win;
      cnt_d   = CW'(HOLD_CYCLES - 1);
    end
    if (drop) begin
      state_d = IDLE;
      grant_d = '0;
      owner_d = '0;
    end
    numero_d = (state_q != IDLE && state_d != IDLE) ? dsh[31:0] : '0;
  end
  // State and registered display outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= 3'(NUM_REQ - 1);
      cnt_q    <= '0;
      numero_q <= '0;
      power_q  <= 1'b0;
      sw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      numero_q <= numero_d;
      power_q  <= state_d != IDLE;
      sw_q     <= grant_d != grant_q;
    end
  end
  assign bus.grant        = grant_q;
  assign bus.owner_id     = owner_q;
  assign bus.numero_out   = numero_q;
  assign bus.power_on     = power_q;
  assign bus.switch_pulse = sw_q;
endmodule
